// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the data-side load/store unit: RV32I load/store
// funct3 codes, the unit's state enum, default memory-map constants and a
// helper that decides whether a funct3 code is a legal load or store.
// -----------------------------------------------------------------------------
package lsu_pkg;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Default memory map: byte address of data word 0 and depth in words
  localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0000_1000;
  localparam int          DMEM_WORDS_DEFAULT = 2048;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    RESP
  } lsu_state_t;

  // Stores only know the signed widths; loads add the unsigned byte/half.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for the load/store unit.
//   funct3  : RV32I load/store width code
//   addr    : low two bits of the byte address (lane select)
//   rdata   : word read from the data BRAM
//   wdata   : store data, right-aligned
//   ld_data : load result, lane extracted and sign/zero extended
//   st_word : word to write back; sub-word stores merge into rdata
// Halfword lanes are chosen by addr[1] only, so an odd halfword address
// simply drops addr[0].
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  byte_shift;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_shift = {addr, 3'b000};

  // Pick the addressed lane out of the read word and extend it
  always_comb begin
    byte_val = rdata[byte_shift +: 8];
    half_val = addr[1] ? rdata[31:16] : rdata[15:0];
    ld_data  = 32'd0;
    case (funct3)
      F3_B:    ld_data = {{24{byte_val[7]}}, byte_val};
      F3_BU:   ld_data = {24'd0, byte_val};
      F3_H:    ld_data = {{16{half_val[15]}}, half_val};
      F3_HU:   ld_data = {16'd0, half_val};
      F3_W:    ld_data = rdata;
      default: ld_data = 32'd0;
    endcase
  end

  // Replace only the target lane of the old word; full-word stores pass through
  always_comb begin
    st_word = wdata;
    case (funct3)
      F3_B: begin
        st_word                  = rdata;
        st_word[byte_shift +: 8] = wdata[7:0];
      end
      F3_H: begin
        st_word = rdata;
        if (addr[1]) begin
          st_word[31:16] = wdata[15:0];
        end else begin
          st_word[15:0] = wdata[15:0];
        end
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Data-side memory access unit between the multi-cycle RV32I core and the
// data BRAM. One request per handshake; a one-cycle resp_valid pulse marks
// completion. The BRAM has no byte strobes, so SB/SH go through a
// read-modify-write (RD -> MERGE -> WR).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE, not in reset)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I load/store funct3
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          formatted load data, 0 for stores and errors
//   resp_err            illegal funct3 / out of range / (optional) misaligned
//   mem_en, mem_we      BRAM enable and write enable
//   mem_addr            BRAM word address
//   mem_wdata           BRAM write data
//   mem_rdata           BRAM read data, one cycle after a read enable
//
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned halfword and
// word accesses as errors; otherwise the ignored low address bits are dropped.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
  parameter int          DMEM_WORDS = DMEM_WORDS_DEFAULT,
  parameter int          ADDR_W     = $clog2(DMEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS) << 2;

  lsu_state_t state;
  lsu_state_t state_next;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wr_word_q;
  logic              err_q;

  logic [31:0]       req_off;
  logic              req_in_range;
  logic              req_misaligned;
  logic              req_err;
  logic              accept;

  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  // Addresses below the base wrap to huge offsets, so one compare covers both ends
  assign req_off      = req_addr - DMEM_BASE;
  assign req_in_range = (req_off < DMEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: req_misaligned = req_addr[0];
      F3_W:        req_misaligned = |req_addr[1:0];
      default:     req_misaligned = 1'b0;
    endcase
  end
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_err = !funct3_legal(req_we, req_funct3) || !req_in_range || req_misaligned;
  assign accept  = req_valid && req_ready;

  lsu_align u_align (
    .funct3  (funct3_q),
    .addr    (lane_q),
    .rdata   (mem_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch; wr_word_q holds SW data directly, or the merged word for SB/SH
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      lane_q    <= 2'd0;
      waddr_q   <= '0;
      wdata_q   <= 32'd0;
      wr_word_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        lane_q    <= req_addr[1:0];
        waddr_q   <= req_off[ADDR_W+1:2];
        wdata_q   <= req_wdata;
        wr_word_q <= req_wdata;
        err_q     <= req_err;
      end
      if (state == MERGE) begin
        wr_word_q <= st_word;
      end
    end
  end

  // Only full-word stores skip the read; errors go straight to the response
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = we_q ? MERGE : RESP;
      MERGE:   state_next = WR;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // BRAM and response outputs decode purely from the current state
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    case (state)
      IDLE: req_ready = !reset;
      RD: begin
        mem_en   = 1'b1;
        mem_addr = waddr_q;
      end
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = wr_word_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'd0 : ld_data;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-side memory access unit between the multi-cycle RV32I core and the data BRAM.
- Accepts one load or store per handshake and formats byte, halfword and word loads with sign or zero extension.
- The data BRAM has no byte strobes, so sub-word stores use a read-modify-write.
- Returns a one-cycle response pulse; the core waits in its MEMORY state until the response arrives.

Parameters:
- DMEM_BASE, 32'h0000_1000, byte address of data word 0.
- DMEM_WORDS, 2048, depth in 32-bit words; must be a power of two.
- ADDR_W, $clog2(DMEM_WORDS), width of the BRAM word address.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data; rs2 value, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  formatted load data; 0 for stores
- resp_err  out  1  illegal funct3, out-of-range address, or (with macro) misaligned access; valid with resp_valid
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset values: the state machine goes to IDLE; req_ready=0 while reset is high, otherwise 1 in IDLE. resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the request and returns to IDLE. No response is issued. Memory is not written unless the edge that samples reset is the WR cycle; mem_* outputs decode from the current state, so that write completes.
- States: IDLE, RD, MERGE, WR, RESP.
- Handshake: a request is accepted when req_valid && req_ready in IDLE. On acceptance the unit latches we, funct3, addr and wdata. req_ready=0 in every state except IDLE. There is no response backpressure; resp_valid is high for exactly one cycle, in RESP, then the unit returns to IDLE.
- Range check: off = req_addr - DMEM_BASE; the address is in range iff off < 4*DMEM_WORDS. mem_addr = off[ADDR_W+1:2].
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Error path (illegal, out of range, or misaligned with macro): IDLE -> RESP. resp_err=1, resp_rdata=0, no mem_en.
- Load path: IDLE -> RD -> RESP.
  - RD drives mem_en=1, mem_we=0.
  - In RESP, resp_rdata is formatted from mem_rdata: byte lane is addr[1:0]; halfword lane is addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
  - Latency: resp_valid is asserted 2 cycles after the accept edge.
- SW path: IDLE -> WR -> RESP. WR drives mem_en=1, mem_we=1, mem_wdata=wdata. resp_valid is asserted 2 cycles after accept.
- SB/SH path: IDLE -> RD -> MERGE -> WR -> RESP.
  - MERGE registers the read word with the target byte or halfword replaced by wdata[7:0] or wdata[15:0]; other lanes are unchanged.
  - WR writes the merged word. resp_valid is asserted 4 cycles after accept.
- A store response always has resp_rdata=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- With the macro defined:
  - Misaligned accesses take the error path with resp_err=1.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- Without the macro: ignored low address bits are dropped and the access proceeds with resp_err=0.
  - Halfword accesses use addr[1].
  - Word accesses ignore addr[1:0].

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t.
  - DMEM_BASE default.
- One combinational sub-module, lsu_align, containing load extract/extend and store merge: inputs funct3, addr[1:0], rdata, wdata; outputs ld_data, st_word.

Test Plan:
- Word at 0x1010 = 32'h8899_AABB; LB at 0x1011 -> resp_rdata=32'hFFFF_FFAA, resp_err=0, resp_valid exactly 2 cycles after accept.
- Same word; LHU at 0x1012 -> 32'h0000_8899; LH at 0x1012 -> 32'hFFFF_8899; LW at 0x1010 -> 32'h8899_AABB.
- SB wdata=32'h1234_5677 at 0x1013, then LW at 0x1010 -> 32'h7799_AABB. Check that the store response is 4 cycles after accept and that mem_we pulses once.
- LW at 0x0FFC, SW at 0x1000+4*DMEM_WORDS, and funct3=3'b011 load -> resp_err=1, resp_rdata=0, mem_en never asserted, response 1 cycle after accept.
- LW at 0x1012:
  - With LSU_MISALIGN_TRAP_EN: resp_err=1, no mem_en.
  - Without it: returns the word at 0x1010, resp_err=0.
- Assert reset during MERGE of an SB -> no mem_we, no resp_valid, req_ready=1 the cycle after reset deasserts, and memory is unchanged.
